sram_req_ctrl: RTL and testbench
================================

SRAM_REQ_CTRL -- requirements
Module: sram_req_ctrl

Interface
REQ-001 Parameters SHALL be: ADDR_W, default 14, word address width; DATA_W, default 32, data width (4 byte lanes); INIT_EN, default 1, zero-fill the SRAM after reset.
REQ-002 CK  in  1  single clock; all state updates on rising edge.
REQ-003 rst  in  1  reset, asynchronous and active-high.
REQ-004 req_valid / req_ready  in / out  1 / 1  request handshake; transfer occurs when both are high in one cycle.
REQ-005 req_write  in  1  1 = write, 0 = read.
REQ-006 req_addr  in  ADDR_W  word address.
REQ-007 req_wdata  in  DATA_W  write data.
REQ-008 req_wstrb  in  4  byte enables; bit i covers data bits [8i+7:8i].
REQ-009 rsp_valid / rsp_ready  out / in  1 / 1  read-response handshake.
REQ-010 rsp_rdata  out  DATA_W  read data.
REQ-011 init_done  out  1  high once the SRAM is usable.
REQ-012 sram_CS  out  1  chip select to the SRAM macro.
REQ-013 sram_OE  out  1  output enable to the SRAM macro.
REQ-014 sram_WEB  out  4  active-low byte write enables to the SRAM macro.
REQ-015 sram_A  out  ADDR_W  address to the SRAM macro.
REQ-016 sram_DI  out  DATA_W  write data to the SRAM macro.
REQ-017 sram_DO  in  DATA_W  registered read data from the SRAM macro; valid the cycle after an access; overwritten by any later access.

Function
REQ-018 The FSM SHALL have two states: INIT and RUN. Reset state is INIT if INIT_EN=1, otherwise RUN.
REQ-019 INIT behaviour: each cycle drive sram_CS=1, sram_WEB=4'h0, sram_DI=0, sram_A=init_addr; init_addr starts at 0 and increments by 1 each cycle; req_ready=0.
REQ-020 INIT exit: when init_addr = 2^ADDR_W-1, the FSM SHALL go to RUN on that edge and set init_done=1 registered. The INIT state lasts exactly 2^ADDR_W cycles.
REQ-021 RUN SHALL drive the SRAM pins combinationally: sram_CS = req_valid & req_ready; sram_A = req_addr; sram_DI = req_wdata; sram_WEB = req_write ? ~req_wstrb : 4'hF.
REQ-022 A write with req_wstrb=0 SHALL still be accepted, SHALL assert CS and SHALL modify no byte.
REQ-023 sram_OE SHALL be 1 at all times.
REQ-024 An accepted read SHALL set rd_pend for exactly the next cycle. In that cycle sram_DO SHALL be pushed into a 2-entry response FIFO, which holds no other state beyond its count and pointers.
REQ-025 Read latency: accept in cycle N SHALL give rsp_valid in cycle N+2 when the FIFO was empty and not blocked. Responses SHALL return in request order.
REQ-026 rsp_valid SHALL equal FIFO non-empty; rsp_rdata SHALL be the head entry, held stable while rsp_valid=1 and rsp_ready=0.
REQ-027 Read credit: in RUN, req_ready SHALL be 1 for reads iff fifo_count + rd_pend < 2, using registered values only; a same-cycle pop SHALL NOT grant credit.
REQ-028 Writes SHALL always be ready in RUN, independent of FIFO state.
REQ-029 Simultaneous FIFO push and pop SHALL leave the count unchanged and keep data order. Count SHALL never exceed 2 or underflow.
REQ-030 A write accepted in cycle N+1 after a read accepted in cycle N SHALL NOT corrupt that read's captured data.

Reset
REQ-031 On rst high, asynchronously: rsp_valid=0, FIFO count/pointers=0, rd_pend=0, init_addr=0, init_done=INIT_EN?0:1, state per REQ-018.
REQ-032 During reset, sram_CS=0 and req_ready=0.
REQ-033 A reset mid-INIT SHALL restart the zero-fill from address 0.
REQ-034 A reset mid-transaction SHALL drop pending responses with no rsp_valid pulse.

Verification
REQ-035 INIT_EN=1, release reset -> 16384 consecutive cycles with CS=1, WEB=0, A=0..0x3FFF; then init_done=1; a read of 0x3FFF returns 0x00000000.
REQ-036 Write 0xDEADBEEF to 0x0010 with strb 4'hF, then write 0x000000AA with strb 4'b0001, then read 0x0010 -> rsp_rdata=0xDEADBEAA, rsp_valid exactly 2 cycles after read accept.
REQ-037 rsp_ready=0 with back-to-back reads of 0x1/0x2/0x3 -> first two accepted; req_ready=0 for the third; writes still accepted; on rsp_ready=1 data returns in order.
REQ-038 FIFO holds 1 entry, read accepted in the same cycle as a pop -> count stays 1, no loss or duplication; alternating read/write each cycle returns correct data.
REQ-039 Assert rst at init_addr=0x0100 -> init_done=0, next CS cycle uses A=0; assert rst with a FIFO entry pending -> rsp_valid=0 immediately, no stale response after release.

Source files
------------

// File: rtl/sram_req_ctrl.sv
// SRAM request controller: zero-fills the macro after reset, then maps valid/ready requests onto SRAM pins.
// Read data lands in a 2-deep response FIFO two cycles after accept; read credit comes from registered occupancy only.
module sram_req_ctrl #(
  parameter int ADDR_W  = 14,
  parameter int DATA_W  = 32,
  parameter bit INIT_EN = 1'b1
) (
  input  logic              CK,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_write,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  input  logic [3:0]        req_wstrb,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [DATA_W-1:0] rsp_rdata,
  output logic              init_done,
  output logic              sram_CS,
  output logic              sram_OE,
  output logic [3:0]        sram_WEB,
  output logic [ADDR_W-1:0] sram_A,
  output logic [DATA_W-1:0] sram_DI,
  input  logic [DATA_W-1:0] sram_DO
);

  typedef enum logic {ST_INIT, ST_RUN} state_t;

  localparam state_t            RST_STATE = INIT_EN ? ST_INIT : ST_RUN;
  localparam logic              RST_DONE  = INIT_EN ? 1'b0 : 1'b1;
  localparam logic [ADDR_W-1:0] LAST_ADDR = '1;

  state_t              state_q, state_d;
  logic [ADDR_W-1:0]   init_addr_q, init_addr_d;
  logic                init_done_q, init_done_d;
  logic                rd_pend_q, rd_pend_d;
  logic [1:0]          cnt_q, cnt_d;
  logic                wr_ptr_q, wr_ptr_d;
  logic                rd_ptr_q, rd_ptr_d;
  logic [DATA_W-1:0]   mem_q [2];

  logic run;
  logic rd_credit;
  logic accept;
  logic push;
  logic pop;

  always_comb begin
    run       = (state_q == ST_RUN);
    // Credit uses registered occupancy only, so a pop in this cycle never frees a slot early.
    rd_credit = (3'(cnt_q) + 3'(rd_pend_q)) < 3'd2;
    req_ready = ~rst & run & (req_write | rd_credit);
    accept    = req_valid & req_ready;
    rsp_valid = (cnt_q != 2'd0);
    rsp_rdata = mem_q[rd_ptr_q];
    push      = rd_pend_q;
    pop       = rsp_valid & rsp_ready;
    init_done = init_done_q;
    sram_OE   = 1'b1;

    if (!run) begin
      sram_CS  = ~rst;
      sram_WEB = 4'h0;
      sram_A   = init_addr_q;
      sram_DI  = '0;
    end else begin
      sram_CS  = accept;
      sram_WEB = req_write ? ~req_wstrb : 4'hF;
      sram_A   = req_addr;
      sram_DI  = req_wdata;
    end
  end

  always_comb begin
    state_d     = state_q;
    init_addr_d = init_addr_q;
    init_done_d = init_done_q;
    if (!run) begin
      init_addr_d = init_addr_q + ADDR_W'(1);
      if (init_addr_q == LAST_ADDR) begin
        state_d     = ST_RUN;
        init_done_d = 1'b1;
      end
    end
    rd_pend_d = accept & ~req_write;
    cnt_d     = cnt_q + 2'(push) - 2'(pop);
    wr_ptr_d  = wr_ptr_q ^ push;
    rd_ptr_d  = rd_ptr_q ^ pop;
  end

  always_ff @(posedge CK or posedge rst) begin
    if (rst) begin
      state_q     <= RST_STATE;
      init_addr_q <= '0;
      init_done_q <= RST_DONE;
      rd_pend_q   <= 1'b0;
      cnt_q       <= 2'd0;
      wr_ptr_q    <= 1'b0;
      rd_ptr_q    <= 1'b0;
    end else begin
      state_q     <= state_d;
      init_addr_q <= init_addr_d;
      init_done_q <= init_done_d;
      rd_pend_q   <= rd_pend_d;
      cnt_q       <= cnt_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
    end
  end

  // Payload storage needs no reset: occupancy alone decides what is visible.
  always_ff @(posedge CK) begin
    if (push) begin
      mem_q[wr_ptr_q] <= sram_DO;
    end
  end

endmodule

// File: tb/tb_sram_req_ctrl.sv
// Directed bench for sram_req_ctrl with a behavioural byte-maskable SRAM model.
module tb_sram_req_ctrl;
  localparam int AW = 14;
  localparam int DW = 32;

  logic          CK = 1'b0;
  logic          rst;
  logic          req_valid, req_ready, req_write;
  logic [AW-1:0] req_addr;
  logic [DW-1:0] req_wdata;
  logic [3:0]    req_wstrb;
  logic          rsp_valid, rsp_ready;
  logic [DW-1:0] rsp_rdata;
  logic          init_done;
  logic          sram_CS, sram_OE;
  logic [3:0]    sram_WEB;
  logic [AW-1:0] sram_A;
  logic [DW-1:0] sram_DI;
  logic [DW-1:0] sram_DO = '0;

  int n_checks = 0;
  int n_fail   = 0;

  logic [DW-1:0] smem [0:(1<<AW)-1];
  logic [DW-1:0] sram_w;
  logic          ok, cs_s;
  logic [3:0]    web_s;

  sram_req_ctrl #(.ADDR_W(AW), .DATA_W(DW), .INIT_EN(1'b1)) dut (
    .CK(CK), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
    .req_addr(req_addr), .req_wdata(req_wdata), .req_wstrb(req_wstrb),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata),
    .init_done(init_done),
    .sram_CS(sram_CS), .sram_OE(sram_OE), .sram_WEB(sram_WEB),
    .sram_A(sram_A), .sram_DI(sram_DI), .sram_DO(sram_DO)
  );

  always #5 CK = ~CK;

  // Registered-output SRAM: any access updates DO with the post-access word.
  always @(posedge CK) begin
    if (sram_CS) begin
      sram_w = smem[sram_A];
      for (int b = 0; b < 4; b++)
        if (!sram_WEB[b]) sram_w[8*b +: 8] = sram_DI[8*b +: 8];
      smem[sram_A] = sram_w;
      sram_DO <= sram_w;
    end
  end

  task automatic issue(input logic wr, input logic [AW-1:0] a, input logic [DW-1:0] d,
                       input logic [3:0] s, output logic acc, output logic cs_seen,
                       output logic [3:0] web_seen);
    acc = 1'b0; cs_seen = 1'b0; web_seen = 4'h0;
    req_valid = 1'b1; req_write = wr; req_addr = a; req_wdata = d; req_wstrb = s;
    for (int i = 0; i < 20; i++) begin
      @(negedge CK);
      if (req_ready === 1'b1) begin
        acc = 1'b1; cs_seen = sram_CS; web_seen = sram_WEB;
        break;
      end
      @(posedge CK); #1;
    end
    if (acc) begin
      @(posedge CK); #1;
    end
    req_valid = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; req_valid = 1'b0; req_write = 1'b0; req_addr = '0;
    req_wdata = '0; req_wstrb = 4'h0; rsp_ready = 1'b1;
    #2;
    n_checks++; if (sram_CS !== 1'b0) begin n_fail++; $display("FAIL rst_cs: got %b want 0", sram_CS); end
    n_checks++; if (rsp_valid !== 1'b0) begin n_fail++; $display("FAIL rst_rsp_valid: got %b want 0", rsp_valid); end
    n_checks++; if (init_done !== 1'b0) begin n_fail++; $display("FAIL rst_init_done: got %b want 0", init_done); end
    n_checks++; if (sram_OE !== 1'b1) begin n_fail++; $display("FAIL rst_oe: got %b want 1", sram_OE); end
    req_valid = 1'b1; req_write = 1'b1; req_wstrb = 4'hF;
    repeat (3) @(posedge CK);
    @(negedge CK);
    n_checks++; if (req_ready !== 1'b0 || sram_CS !== 1'b0) begin
      n_fail++; $display("FAIL rst_hold: got ready=%b cs=%b want 0/0", req_ready, sram_CS); end
    req_valid = 1'b0;
    @(posedge CK); #1;
  endtask

  task automatic test_init_restart();
    int errs = 0;
    rst = 1'b0;
    for (int i = 0; i < 256; i++) begin
      @(negedge CK);
      if (sram_CS !== 1'b1 || sram_WEB !== 4'h0 || sram_A !== AW'(i) || req_ready !== 1'b0) errs++;
      @(posedge CK);
    end
    @(negedge CK);
    n_checks++; if (errs != 0) begin n_fail++; $display("FAIL init_prefix: got %0d bad cycles want 0", errs); end
    n_checks++; if (sram_A !== 14'h0100) begin n_fail++; $display("FAIL init_at_0x100: got %h want 0100", sram_A); end
    rst = 1'b1;
    #1;
    n_checks++; if (sram_CS !== 1'b0 || init_done !== 1'b0) begin
      n_fail++; $display("FAIL init_mid_rst: got cs=%b done=%b want 0/0", sram_CS, init_done); end
    repeat (2) @(posedge CK);
    #1;
  endtask

  task automatic test_init_full();
    int errs = 0;
    logic [AW-1:0] a0 = '1;
    rst = 1'b0;
    for (int i = 0; i < (1 << AW); i++) begin
      @(negedge CK);
      if (i == 0) a0 = sram_A;
      if (sram_CS !== 1'b1 || sram_WEB !== 4'h0 || sram_A !== AW'(i) ||
          init_done !== 1'b0 || req_ready !== 1'b0) errs++;
      @(posedge CK);
    end
    n_checks++; if (a0 !== 14'h0000) begin n_fail++; $display("FAIL init_restart_a0: got %h want 0000", a0); end
    n_checks++; if (errs != 0) begin n_fail++; $display("FAIL init_seq: got %0d bad cycles want 0", errs); end
    @(negedge CK);
    n_checks++; if (init_done !== 1'b1) begin n_fail++; $display("FAIL init_done: got %b want 1", init_done); end
    n_checks++; if (sram_CS !== 1'b0) begin n_fail++; $display("FAIL run_idle_cs: got %b want 0", sram_CS); end
    @(posedge CK); #1;
    issue(1'b0, 14'h3FFF, '0, 4'h0, ok, cs_s, web_s);
    n_checks++; if (ok !== 1'b1) begin n_fail++; $display("FAIL rd_last_accept: got %b want 1", ok); end
    @(negedge CK);
    n_checks++; if (rsp_valid !== 1'b0) begin n_fail++; $display("FAIL rd_last_lat1: got %b want 0", rsp_valid); end
    @(posedge CK); @(negedge CK);
    n_checks++; if (rsp_valid !== 1'b1 || rsp_rdata !== 32'h0) begin
      n_fail++; $display("FAIL rd_last_data: got v=%b d=%h want 1/00000000", rsp_valid, rsp_rdata); end
    @(posedge CK); #1;
  endtask

  task automatic test_write_merge();
    issue(1'b1, 14'h0010, 32'hDEADBEEF, 4'hF, ok, cs_s, web_s);
    n_checks++; if (ok !== 1'b1 || cs_s !== 1'b1 || web_s !== 4'h0) begin
      n_fail++; $display("FAIL wr_full: got ok=%b cs=%b web=%h want 1/1/0", ok, cs_s, web_s); end
    issue(1'b1, 14'h0010, 32'h000000AA, 4'b0001, ok, cs_s, web_s);
    n_checks++; if (ok !== 1'b1 || web_s !== 4'hE) begin
      n_fail++; $display("FAIL wr_byte0: got ok=%b web=%h want 1/e", ok, web_s); end
    issue(1'b1, 14'h0010, 32'h12345678, 4'h0, ok, cs_s, web_s);
    n_checks++; if (ok !== 1'b1 || cs_s !== 1'b1 || web_s !== 4'hF) begin
      n_fail++; $display("FAIL wr_nostrb: got ok=%b cs=%b web=%h want 1/1/f", ok, cs_s, web_s); end
    issue(1'b0, 14'h0010, '0, 4'h0, ok, cs_s, web_s);
    @(negedge CK);
    n_checks++; if (rsp_valid !== 1'b0) begin n_fail++; $display("FAIL merge_lat1: got %b want 0", rsp_valid); end
    @(posedge CK); @(negedge CK);
    n_checks++; if (rsp_valid !== 1'b1 || rsp_rdata !== 32'hDEADBEAA) begin
      n_fail++; $display("FAIL merge_data: got v=%b d=%h want 1/deadbeaa", rsp_valid, rsp_rdata); end
    @(posedge CK); #1;
  endtask

  task automatic test_backpressure();
    int hold_errs = 0;
    issue(1'b1, 14'h0001, 32'h11111111, 4'hF, ok, cs_s, web_s);
    issue(1'b1, 14'h0002, 32'h22222222, 4'hF, ok, cs_s, web_s);
    issue(1'b1, 14'h0003, 32'h33333333, 4'hF, ok, cs_s, web_s);
    rsp_ready = 1'b0;
    req_valid = 1'b1; req_write = 1'b0; req_addr = 14'h0001;
    @(negedge CK);
    n_checks++; if (req_ready !== 1'b1) begin n_fail++; $display("FAIL bp_rd1_ready: got %b want 1", req_ready); end
    @(posedge CK); #1; req_addr = 14'h0002;
    @(negedge CK);
    n_checks++; if (req_ready !== 1'b1) begin n_fail++; $display("FAIL bp_rd2_ready: got %b want 1", req_ready); end
    @(posedge CK); #1; req_addr = 14'h0003;
    @(negedge CK);
    n_checks++; if (req_ready !== 1'b0) begin n_fail++; $display("FAIL bp_rd3_blocked: got %b want 0", req_ready); end
    for (int i = 0; i < 3; i++) begin
      @(posedge CK); #1; @(negedge CK);
      if (req_ready !== 1'b0 || rsp_valid !== 1'b1 || rsp_rdata !== 32'h11111111) hold_errs++;
    end
    n_checks++; if (hold_errs != 0) begin n_fail++; $display("FAIL bp_hold: got %0d bad cycles want 0", hold_errs); end
    req_write = 1'b1; req_addr = 14'h0005; req_wdata = 32'h55555555; req_wstrb = 4'hF;
    #1;
    n_checks++; if (req_ready !== 1'b1) begin n_fail++; $display("FAIL bp_write_ready: got %b want 1", req_ready); end
    @(posedge CK); #1; req_valid = 1'b0; rsp_ready = 1'b1;
    @(negedge CK);
    n_checks++; if (rsp_valid !== 1'b1 || rsp_rdata !== 32'h11111111) begin
      n_fail++; $display("FAIL bp_first: got v=%b d=%h want 1/11111111", rsp_valid, rsp_rdata); end
    @(posedge CK); #1; @(negedge CK);
    n_checks++; if (rsp_valid !== 1'b1 || rsp_rdata !== 32'h22222222) begin
      n_fail++; $display("FAIL bp_second: got v=%b d=%h want 1/22222222", rsp_valid, rsp_rdata); end
    @(posedge CK); #1; @(negedge CK);
    n_checks++; if (rsp_valid !== 1'b0) begin n_fail++; $display("FAIL bp_drained: got %b want 0", rsp_valid); end
    @(posedge CK); #1;
    issue(1'b0, 14'h0003, '0, 4'h0, ok, cs_s, web_s);
    @(posedge CK); @(negedge CK);
    n_checks++; if (rsp_valid !== 1'b1 || rsp_rdata !== 32'h33333333) begin
      n_fail++; $display("FAIL bp_third: got v=%b d=%h want 1/33333333", rsp_valid, rsp_rdata); end
    @(posedge CK); #1;
  endtask

  task automatic test_pop_push();
    rsp_ready = 1'b0;
    req_valid = 1'b1; req_write = 1'b0; req_addr = 14'h0001;
    @(negedge CK); @(posedge CK); #1; req_addr = 14'h0002;
    @(negedge CK); @(posedge CK); #1; req_addr = 14'h0003; rsp_ready = 1'b1;
    @(negedge CK);
    n_checks++; if (req_ready !== 1'b0) begin n_fail++; $display("FAIL pp_no_credit: got %b want 0", req_ready); end
    n_checks++; if (rsp_valid !== 1'b1 || rsp_rdata !== 32'h11111111) begin
      n_fail++; $display("FAIL pp_head: got v=%b d=%h want 1/11111111", rsp_valid, rsp_rdata); end
    @(posedge CK); #1; req_valid = 1'b0;
    @(negedge CK);
    n_checks++; if (rsp_valid !== 1'b1 || rsp_rdata !== 32'h22222222) begin
      n_fail++; $display("FAIL pp_after_pushpop: got v=%b d=%h want 1/22222222", rsp_valid, rsp_rdata); end
    @(posedge CK); #1; @(negedge CK);
    n_checks++; if (rsp_valid !== 1'b0) begin n_fail++; $display("FAIL pp_drained: got %b want 0", rsp_valid); end
    @(posedge CK); #1;
  endtask

  task automatic test_alternate();
    logic          t_wr [6] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
    logic [AW-1:0] t_a  [6] = '{14'h20, 14'h20, 14'h20, 14'h20, 14'h21, 14'h21};
    logic [DW-1:0] t_d  [6] = '{32'hCAFE0001, 32'h0, 32'hCAFE0002, 32'h0, 32'hCAFE0003, 32'h0};
    logic [DW-1:0] got [$];
    int rdy_errs = 0;
    rsp_ready = 1'b1;
    for (int i = 0; i < 6; i++) begin
      req_valid = 1'b1; req_write = t_wr[i]; req_addr = t_a[i]; req_wdata = t_d[i]; req_wstrb = 4'hF;
      @(negedge CK);
      if (req_ready !== 1'b1) rdy_errs++;
      if (rsp_valid === 1'b1) got.push_back(rsp_rdata);
      @(posedge CK); #1;
    end
    req_valid = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge CK);
      if (rsp_valid === 1'b1) got.push_back(rsp_rdata);
      @(posedge CK); #1;
    end
    n_checks++; if (rdy_errs != 0) begin n_fail++; $display("FAIL alt_ready: got %0d stalls want 0", rdy_errs); end
    n_checks++; if (got.size() != 3) begin n_fail++; $display("FAIL alt_count: got %0d want 3", got.size()); end
    else begin
      n_checks++; if (got[0] !== 32'hCAFE0001 || got[1] !== 32'hCAFE0002 || got[2] !== 32'hCAFE0003) begin
        n_fail++; $display("FAIL alt_data: got %h %h %h want cafe0001 cafe0002 cafe0003", got[0], got[1], got[2]); end
    end
  endtask

  task automatic test_reset_pending();
    int stale = 0;
    rsp_ready = 1'b0;
    issue(1'b0, 14'h0010, '0, 4'h0, ok, cs_s, web_s);
    @(posedge CK); @(negedge CK);
    n_checks++; if (rsp_valid !== 1'b1) begin n_fail++; $display("FAIL rp_pending: got %b want 1", rsp_valid); end
    rst = 1'b1;
    #1;
    n_checks++; if (rsp_valid !== 1'b0 || req_ready !== 1'b0) begin
      n_fail++; $display("FAIL rp_drop: got v=%b rdy=%b want 0/0", rsp_valid, req_ready); end
    repeat (2) @(posedge CK);
    #1; rst = 1'b0; rsp_ready = 1'b1;
    for (int i = 0; i < (1 << AW) + 4; i++) begin
      @(negedge CK);
      if (rsp_valid !== 1'b0) stale++;
      @(posedge CK);
    end
    n_checks++; if (stale != 0) begin n_fail++; $display("FAIL rp_stale: got %0d valid cycles want 0", stale); end
    n_checks++; if (init_done !== 1'b1) begin n_fail++; $display("FAIL rp_reinit: got %b want 1", init_done); end
  endtask

  initial begin
    for (int i = 0; i < (1 << AW); i++) smem[i] = 32'hA5A50000 | i;
    test_reset();
    test_init_restart();
    test_init_full();
    test_write_merge();
    test_backpressure();
    test_pop_push();
    test_alternate();
    test_reset_pending();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not complete within time limit");
    $fatal(1);
  end

endmodule
